// File: rtl/forex_update_ingress_if.sv
// Avalon-MM register port plus solver update handshake for forex_update_ingress.
// The slave modport is the ingress block; the master modport is the HPS/solver side.
interface forex_update_ingress_if #(
    parameter int unsigned PRED_W   = 3,
    parameter int unsigned WEIGHT_W = 32
);
    logic                chipselect;
    logic                write;
    logic                read;
    logic [2:0]          address;
    logic [31:0]         writedata;
    logic [31:0]         readdata;

    logic                upd_valid;
    logic                upd_ready;
    logic [PRED_W-1:0]   upd_src;
    logic [PRED_W-1:0]   upd_dst;
    logic [WEIGHT_W-1:0] upd_weight;
    logic                solver_reset;
    logic                solver_done;
    logic                busy;

    modport slave (
        input  chipselect, write, read, address, writedata,
        input  upd_ready, solver_done,
        output readdata,
        output upd_valid, upd_src, upd_dst, upd_weight, solver_reset, busy
    );

    modport master (
        output chipselect, write, read, address, writedata,
        output upd_ready, solver_done,
        input  readdata,
        input  upd_valid, upd_src, upd_dst, upd_weight, solver_reset, busy
    );
endinterface

// File: rtl/forex_update_ingress.sv
// Avalon-MM ingress queue replaying edge-weight updates to the Bellman-Ford solver.
// Optional RUN-state watchdog is compiled in when FOREX_TIMEOUT_EN is defined.
module forex_update_ingress #(
    parameter int unsigned PRED_W         = 3,
    parameter int unsigned WEIGHT_W       = 32,
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  reset,
    forex_update_ingress_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = 2 * PRED_W + WEIGHT_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_KICK,
        S_RUN
    } state_t;

    state_t            state;
    state_t            state_nx;

    logic [PRED_W-1:0] stage_src;
    logic [PRED_W-1:0] stage_dst;

    logic [EW-1:0]     mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [EW-1:0]     head;

    logic              sticky_ovf;
    logic              sticky_self;
    logic              sticky_tout;
    logic [15:0]       drop_cnt;

    logic              wr_en;
    logic              rd_en;
    logic              wr_stage;
    logic              wr_commit;
    logic              wr_ctrl;
    logic              flush;
    logic              clear;
    logic              empty;
    logic              full;
    logic              self_loop;
    logic              commit_ok;
    logic              commit_ovf;
    logic              commit_self;
    logic              pop;
    logic              tout_hit;
    logic              upd_valid_c;
    logic              solver_reset_c;
    logic              busy_c;
    logic              run_expired;
    logic [31:0]       status;

    logic              unused_wdata;
    assign unused_wdata = ^bus.writedata;

    assign wr_en     = bus.chipselect & bus.write;
    assign rd_en     = bus.chipselect & bus.read;
    assign wr_stage  = wr_en && (bus.address == 3'd0);
    assign wr_commit = wr_en && (bus.address == 3'd1);
    assign wr_ctrl   = wr_en && (bus.address == 3'd2);
    assign flush     = wr_ctrl & bus.writedata[0];
    assign clear     = wr_ctrl & bus.writedata[1];

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign self_loop = (stage_src == stage_dst);

    // A full FIFO still accepts a commit when the head leaves in the same cycle.
    assign commit_ok   = wr_commit & ~flush & ~self_loop & (~full | pop);
    assign commit_ovf  = wr_commit & ~flush & ~self_loop & full & ~pop;
    assign commit_self = wr_commit & ~flush & self_loop;

    // FIFO pointers and occupancy; flush overrides any push or pop.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (commit_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({commit_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (commit_ok) begin
            mem[wr_ptr] <= {stage_src, stage_dst, bus.writedata[WEIGHT_W-1:0]};
        end
    end

    assign head = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_src   <= '0;
            stage_dst   <= '0;
            sticky_ovf  <= 1'b0;
            sticky_self <= 1'b0;
            sticky_tout <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            if (wr_stage) begin
                stage_src <= bus.writedata[2*PRED_W-1:PRED_W];
                stage_dst <= bus.writedata[PRED_W-1:0];
            end
            if (clear) begin
                sticky_ovf  <= 1'b0;
                sticky_self <= 1'b0;
                sticky_tout <= 1'b0;
                drop_cnt    <= '0;
            end else begin
                if (commit_ovf) begin
                    sticky_ovf <= 1'b1;
                end
                if (commit_self) begin
                    sticky_self <= 1'b1;
                end
                if (tout_hit) begin
                    sticky_tout <= 1'b1;
                end
                if ((commit_ovf || commit_self) && (drop_cnt != '1)) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end
        end
    end

`ifdef FOREX_TIMEOUT_EN
    logic [31:0] run_cnt;

    always_ff @(posedge clk) begin
        if (reset || (state != S_RUN)) begin
            run_cnt <= '0;
        end else begin
            run_cnt <= run_cnt + 32'd1;
        end
    end

    assign run_expired = (state == S_RUN) && (run_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
    localparam int unsigned timeout_unused = TIMEOUT_CYCLES;
    assign run_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // A handshake coinciding with a flush completes, so the solver never sees a half-delivered update.
    always_comb begin
        state_nx       = state;
        pop            = 1'b0;
        upd_valid_c    = 1'b0;
        solver_reset_c = 1'b0;
        tout_hit       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty && !flush) begin
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                upd_valid_c = 1'b1;
                if (bus.upd_ready) begin
                    pop      = 1'b1;
                    state_nx = S_KICK;
                end else if (flush) begin
                    state_nx = S_IDLE;
                end
            end
            S_KICK: begin
                solver_reset_c = 1'b1;
                state_nx       = S_RUN;
            end
            S_RUN: begin
                if (bus.solver_done) begin
                    state_nx = S_IDLE;
                end else if (run_expired) begin
                    tout_hit       = 1'b1;
                    solver_reset_c = 1'b1;
                    state_nx       = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign busy_c = (state != S_IDLE);

    assign bus.upd_valid    = upd_valid_c;
    assign bus.solver_reset = solver_reset_c;
    assign bus.busy         = busy_c;
    assign bus.upd_src      = head[EW-1 -: PRED_W];
    assign bus.upd_dst      = head[WEIGHT_W +: PRED_W];
    assign bus.upd_weight   = head[WEIGHT_W-1:0];

    assign status = {16'd0, 8'(count), 2'b00, busy_c, sticky_tout,
                     sticky_self, sticky_ovf, full, empty};

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.readdata <= '0;
        end else if (rd_en) begin
            case (bus.address)
                3'd0:    bus.readdata <= status;
                3'd1:    bus.readdata <= {16'd0, drop_cnt};
                3'd2:    bus.readdata <= 32'({stage_src, stage_dst});
                default: bus.readdata <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_forex_update_ingress.sv
// Randomized bench for forex_update_ingress against a queue-based model of the update path.
module tb_forex_update_ingress;
    localparam int unsigned PRED_W         = 3;
    localparam int unsigned WEIGHT_W       = 32;
    localparam int unsigned DEPTH          = 8;
    localparam int unsigned TIMEOUT_CYCLES = 16;
    localparam int unsigned EW             = 2 * PRED_W + WEIGHT_W;
`ifdef FOREX_TIMEOUT_EN
    localparam logic [31:0] STAT_MASK = ~32'h30;
`else
    localparam logic [31:0] STAT_MASK = ~32'h20;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    forex_update_ingress_if #(.PRED_W(PRED_W), .WEIGHT_W(WEIGHT_W)) bus ();

    forex_update_ingress #(
        .PRED_W(PRED_W),
        .WEIGHT_W(WEIGHT_W),
        .DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Reference model: pending updates in commit order plus the register file.
    logic [EW-1:0]     m_q[$];
    logic [PRED_W-1:0] m_src = '0;
    logic [PRED_W-1:0] m_dst = '0;
    logic              m_ovf = 1'b0;
    logic              m_self = 1'b0;
    logic [15:0]       m_drop = '0;

    bit          rd_pend = 0;
    logic [31:0] rd_exp, rd_mask, last_rd;
    logic [2:0]  rd_addr;
    bit          done_en = 1;
    int          done_wait = 0;
    bit          prev_hs = 0;
    int unsigned cyc = 0, n_hs = 0, n_kick = 0, n_valid = 0;
    int          kick_cyc = -1;

    function automatic logic [31:0] m_status();
        return {16'd0, 8'(m_q.size()), 2'b00, 1'b0, 1'b0, m_self, m_ovf,
                m_q.size() == DEPTH, m_q.size() == 0};
    endfunction

    function automatic void m_drop_inc();
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
    endfunction

    // One clock: called at a negedge with inputs already driven.
    task automatic step();
        logic          hs;
        logic [EW-1:0] e;
        logic [31:0]   wd;
        if (done_wait > 0) begin
            done_wait--;
            bus.solver_done = (done_wait == 0);
        end else begin
            bus.solver_done = 1'b0;
        end
        hs = bus.upd_valid && bus.upd_ready;
        rd_pend = 0;
        if (reset) begin
            m_q.delete();
            m_src = '0; m_dst = '0; m_ovf = 0; m_self = 0; m_drop = '0;
            done_wait = 0;
            prev_hs = 0;
        end else begin
`ifdef FOREX_TIMEOUT_EN
            if (prev_hs) check("kick_after_handshake", 32'(bus.solver_reset), 32'd1);
`else
            check("kick_follows_handshake", 32'(bus.solver_reset), 32'(prev_hs));
`endif
            if (bus.upd_valid) n_valid++;
            if (bus.solver_reset) begin
                n_kick++;
                kick_cyc = int'(cyc);
                if (done_en) begin
                    done_wait = 1 + int'($urandom_range(0, 3));
                    bus.solver_done = ($urandom_range(0, 1) == 1);
                end
            end
            if (bus.chipselect && bus.read) begin
                rd_pend = 1;
                rd_addr = bus.address;
                rd_mask = '1;
                case (bus.address)
                    3'd0: begin rd_exp = m_status(); rd_mask = STAT_MASK; end
                    3'd1: rd_exp = {16'd0, m_drop};
                    3'd2: rd_exp = 32'({m_src, m_dst});
                    default: rd_exp = '0;
                endcase
            end
            if (hs) begin
                n_hs++;
                check("handshake_has_entry", 32'(m_q.size() != 0), 32'd1);
                if (m_q.size() != 0) begin
                    e = m_q.pop_front();
                    check("upd_src", 32'(bus.upd_src), 32'(e[EW-1 -: PRED_W]));
                    check("upd_dst", 32'(bus.upd_dst), 32'(e[WEIGHT_W +: PRED_W]));
                    check("upd_weight", bus.upd_weight, e[WEIGHT_W-1:0]);
                end
            end
            if (bus.chipselect && bus.write) begin
                wd = bus.writedata;
                case (bus.address)
                    3'd0: begin
                        m_src = wd[2*PRED_W-1:PRED_W];
                        m_dst = wd[PRED_W-1:0];
                    end
                    3'd1: begin
                        if (m_src == m_dst) begin
                            m_self = 1; m_drop_inc();
                        end else if (m_q.size() == DEPTH) begin
                            m_ovf = 1; m_drop_inc();
                        end else begin
                            m_q.push_back({m_src, m_dst, wd[WEIGHT_W-1:0]});
                        end
                    end
                    3'd2: begin
                        if (wd[0]) m_q.delete();
                        if (wd[1]) begin m_ovf = 0; m_self = 0; m_drop = '0; end
                    end
                    default: ;
                endcase
            end
            prev_hs = hs;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (rd_pend) begin
            last_rd = bus.readdata;
            check($sformatf("readdata_addr%0d", rd_addr), bus.readdata & rd_mask, rd_exp & rd_mask);
        end
    endtask

    task automatic idle_bus();
        bus.chipselect = 0; bus.write = 0; bus.read = 0;
        bus.address = '0; bus.writedata = '0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.chipselect = 1; bus.write = 1; bus.read = 0; bus.address = a; bus.writedata = d;
        step();
        idle_bus();
    endtask

    task automatic rd(input logic [2:0] a);
        bus.chipselect = 1; bus.write = 0; bus.read = 1; bus.address = a;
        step();
        idle_bus();
    endtask

    task automatic rdwr(input logic [2:0] a, input logic [31:0] d);
        bus.chipselect = 1; bus.write = 1; bus.read = 1; bus.address = a; bus.writedata = d;
        step();
        idle_bus();
    endtask

    task automatic commit(input int unsigned s, input int unsigned d, input logic [31:0] w);
        wr(3'd0, 32'((s << PRED_W) | d));
        wr(3'd1, w);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) step();
    endtask

    task automatic drain(input int unsigned budget, input string tag);
        int unsigned k = 0;
        while ((bus.busy || m_q.size() != 0) && k < budget) begin
            step();
            k++;
        end
        check(tag, 32'(k < budget), 32'd1);
    endtask

    initial begin
        int unsigned hs0, kick0, valid0, c0, r;
        idle_bus();
        bus.upd_ready = 0;
        bus.solver_done = 0;
        reset = 1;
        @(negedge clk);
        step();
        step();
        reset = 0;
        check("reset_upd_valid", 32'(bus.upd_valid), 32'd0);
        check("reset_solver_reset", 32'(bus.solver_reset), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_readdata", bus.readdata, 32'd0);
        rd(3'd0);
        check("reset_status", last_rd, 32'h1);
        rd(3'd2);

        // Single update with ready already high.
        bus.upd_ready = 1;
        valid0 = n_valid;
        wr(3'd0, 32'h0A);
        wr(3'd1, 32'h1234);
        c0 = cyc;
        drain(50, "single_drain");
        check("single_latency", 32'(kick_cyc), 32'(c0 + 2));
        check("single_valid_cycles", n_valid - valid0, 32'd1);
        check("single_busy_low", 32'(bus.busy), 32'd0);

        // Overflow with solver stalled.
        bus.upd_ready = 0;
        hs0 = n_hs;
        for (int unsigned i = 0; i < 9; i++) commit(i % 8, (i + 1) % 8, $urandom);
        rd(3'd0);
        check("ovf_status", last_rd, 32'h0000_0826);
        rd(3'd1);
        check("ovf_drops", last_rd, 32'd1);
        bus.upd_ready = 1;
        drain(200, "ovf_drain");
        check("ovf_drained", n_hs - hs0, 32'd8);
        wr(3'd2, 32'h2);

        // Self-loop rejection.
        valid0 = n_valid;
        commit(3, 3, 32'hDEAD);
        idle(4);
        rd(3'd0);
        check("self_status", last_rd, 32'h09);
        rd(3'd1);
        check("self_drops", last_rd, 32'd1);
        check("self_no_valid", n_valid - valid0, 32'd0);
        wr(3'd2, 32'h2);

        // Flush while the head is stalled in ISSUE.
        bus.upd_ready = 0;
        for (int unsigned i = 0; i < 3; i++) commit(i, i + 4, $urandom);
        check("stall_valid", 32'(bus.upd_valid), 32'd1);
        kick0 = n_kick;
        wr(3'd2, 32'h1);
        check("flush_valid_drop", 32'(bus.upd_valid), 32'd0);
        idle(5);
        check("flush_no_kick", n_kick - kick0, 32'd0);
        check("flush_idle", 32'(bus.busy), 32'd0);
        rd(3'd0);
        check("flush_status", last_rd, 32'h01);

`ifdef FOREX_TIMEOUT_EN
        // Watchdog: solver never finishes.
        done_en = 0;
        bus.upd_ready = 1;
        hs0 = n_hs;
        commit(1, 6, 32'h11);
        commit(2, 6, 32'h22);
        idle(60);
        rd(3'd0);
        check("timeout_bit", 32'(last_rd[4]), 32'd1);
        check("timeout_next_issued", n_hs - hs0, 32'd2);
        wr(3'd2, 32'h2);
        done_en = 1;
`endif

        // Reset while RUN holds with entries queued.
        done_en = 0;
        bus.upd_ready = 1;
        commit(5, 5, 32'h1);
        commit(1, 4, $urandom);
        commit(2, 5, $urandom);
        commit(3, 6, $urandom);
        idle(8);
`ifndef FOREX_TIMEOUT_EN
        idle(40);
        check("run_holds_busy", 32'(bus.busy), 32'd1);
`endif
        rd(3'd0);
        reset = 1;
        step();
        reset = 0;
        check("rst_upd_valid", 32'(bus.upd_valid), 32'd0);
        check("rst_solver_reset", 32'(bus.solver_reset), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_readdata", bus.readdata, 32'd0);
        rd(3'd0);
        check("rst_status", last_rd, 32'h01);
        rd(3'd1);
        check("rst_drops", last_rd, 32'd0);
        done_en = 1;

        // Randomized traffic.
        for (int unsigned i = 0; i < 3000; i++) begin
            bus.upd_ready = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 99);
            if (r < 25)      wr(3'd0, $urandom);
            else if (r < 50) wr(3'd1, $urandom);
            else if (r < 52) wr(3'd2, 32'h1);
            else if (r < 54) wr(3'd2, 32'h2);
            else if (r < 55) wr(3'd2, 32'h3);
            else if (r < 57) wr(3'($urandom_range(3, 7)), $urandom);
            else if (r < 72) rd(3'($urandom_range(0, 7)));
            else if (r < 76) rdwr(3'($urandom_range(0, 2)), $urandom);
            else             step();
        end
        bus.upd_ready = 1;
        drain(500, "final_drain");
`ifndef FOREX_TIMEOUT_EN
        check("kicks_match_handshakes", n_kick, n_hs);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
